// File: rtl/rf_pkg.sv
// Shared constants for the architectural register file.
// Provides data width, register count, index width, ROB tag width and the
// reserved "no pending writer" tag value used by the top and its read ports.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int TAG_W     = 5;

    // Valid ROB tags run 1..ROB_SIZE; tag 0 is reserved for "value valid".
    localparam int ROB_SIZE  = 31;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   i_idx          register index being read
//   i_vals/i_tags  current architectural values and pending rename tags
//   i_commit_*     retiring instruction (valid already qualified by rdy_in)
//   o_val/o_label  value and pending tag seen by the issuing instruction
module rf_read_port
    import rf_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic [XLEN-1:0]      i_vals [NREG],
    input  logic [TAG_W-1:0]     i_tags [NREG],
    input  logic                 i_commit_valid,
    input  logic [REG_IDX_W-1:0] i_commit_rd,
    input  logic [XLEN-1:0]      i_commit_res,
    input  logic [TAG_W-1:0]     i_commit_lab,
    output logic [XLEN-1:0]      o_val,
    output logic [TAG_W-1:0]     o_label
);

    logic w_bypass;

    // A retiring write only satisfies the reader when it is the youngest
    // writer of that register, i.e. its tag still owns the register.
    assign w_bypass = i_commit_valid && (i_commit_rd == i_idx) &&
                      (i_tags[i_idx] == i_commit_lab);

    always_comb begin
        o_val   = i_vals[i_idx];
        o_label = i_tags[i_idx];
        if (i_idx == '0) begin
            o_val   = '0;
            o_label = TAG_NONE;
        end else if (w_bypass) begin
            o_val   = i_commit_res;
            o_label = TAG_NONE;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, feeding the ROB.
// Ports:
//   clk, rst_in (async active-low), rdy_in (global enable)
//   rs1_addr/rs2_addr -> rf_val1/rf_val2, rf_label1/rf_label2 (combinational)
//   rename_en/rename_rd/rename_tag   destination tag of the issuing instruction
//   commit_en/commit_rd/commit_res/commit_lab   ROB retirement
//   flush_in   mispredict flush, drops every pending tag
module register_file
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rf_val1,
    output logic [XLEN-1:0]      rf_val2,
    output logic [TAG_W-1:0]     rf_label1,
    output logic [TAG_W-1:0]     rf_label2,
    input  logic                 rename_en,
    input  logic [REG_IDX_W-1:0] rename_rd,
    input  logic [TAG_W-1:0]     rename_tag,
    input  logic                 commit_en,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [XLEN-1:0]      commit_res,
    input  logic [TAG_W-1:0]     commit_lab,
    input  logic                 flush_in
);

    logic [XLEN-1:0]  r_val [NREG];
    logic [TAG_W-1:0] r_tag [NREG];

    logic w_commit_valid;

    assign w_commit_valid = commit_en && rdy_in;

    rf_read_port u_read1 (
        .i_idx          (rs1_addr),
        .i_vals         (r_val),
        .i_tags         (r_tag),
        .i_commit_valid (w_commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_res   (commit_res),
        .i_commit_lab   (commit_lab),
        .o_val          (rf_val1),
        .o_label        (rf_label1)
    );

    rf_read_port u_read2 (
        .i_idx          (rs2_addr),
        .i_vals         (r_val),
        .i_tags         (r_tag),
        .i_commit_valid (w_commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_res   (commit_res),
        .i_commit_lab   (commit_lab),
        .o_val          (rf_val2),
        .o_label        (rf_label2)
    );

    // Write side. Statement order encodes priority: the commit tag-clear is
    // issued first so that a flush or a same-register rename later in the
    // block overrides it. Register 0 is never written, so its tag stays 0.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= TAG_NONE;
            end
        end else if (rdy_in) begin
            if (commit_en && (commit_rd != '0)) begin
                r_val[commit_rd] <= commit_res;
                if (r_tag[commit_rd] == commit_lab) begin
                    r_tag[commit_rd] <= TAG_NONE;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < NREG; i++) begin
                    r_tag[i] <= TAG_NONE;
                end
            end else if (rename_en && (rename_rd != '0)) begin
                r_tag[rename_rd] <= rename_tag;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    import rf_pkg::*;

    logic                 clk;
    logic                 rst_in;
    logic                 rdy_in;
    logic [REG_IDX_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]      rf_val1, rf_val2;
    logic [TAG_W-1:0]     rf_label1, rf_label2;
    logic                 rename_en;
    logic [REG_IDX_W-1:0] rename_rd;
    logic [TAG_W-1:0]     rename_tag;
    logic                 commit_en;
    logic [REG_IDX_W-1:0] commit_rd;
    logic [XLEN-1:0]      commit_res;
    logic [TAG_W-1:0]     commit_lab;
    logic                 flush_in;

    int passCount;
    int checkCount;
    bit compareOn;

    logic [XLEN-1:0]  mVal [NREG];
    logic [TAG_W-1:0] mTag [NREG];

    register_file dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rf_val1    (rf_val1),
        .rf_val2    (rf_val2),
        .rf_label1  (rf_label1),
        .rf_label2  (rf_label2),
        .rename_en  (rename_en),
        .rename_rd  (rename_rd),
        .rename_tag (rename_tag),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .flush_in   (flush_in)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NREG; i++) begin
            mVal[i] = '0;
            mTag[i] = '0;
        end
    endtask

    // What a reader must see: x0 is hardwired, a live commit owning the
    // register is visible immediately, otherwise the stored state.
    task automatic modelRead(input logic [REG_IDX_W-1:0] idx,
                             output logic [XLEN-1:0] v, output logic [TAG_W-1:0] l);
        if (idx == 0) begin
            v = 0; l = 0;
        end else if (commit_en && rdy_in && commit_rd == idx && mTag[idx] == commit_lab) begin
            v = commit_res; l = 0;
        end else begin
            v = mVal[idx]; l = mTag[idx];
        end
    endtask

    always @(negedge rst_in) clearModel();

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        logic [TAG_W-1:0] nextTag [NREG];
        if (rst_in && rdy_in) begin
            for (int i = 0; i < NREG; i++) nextTag[i] = mTag[i];
            if (commit_en && commit_rd != 0) begin
                mVal[commit_rd] = commit_res;
                if (mTag[commit_rd] == commit_lab) nextTag[commit_rd] = 0;
            end
            if (flush_in) begin
                for (int i = 0; i < NREG; i++) nextTag[i] = 0;
            end else if (rename_en && rename_rd != 0) begin
                nextTag[rename_rd] = rename_tag;
            end
            for (int i = 0; i < NREG; i++) mTag[i] = nextTag[i];
        end
    end

    // Cycle-by-cycle compare of both read ports against the model.
    always @(negedge clk) begin
        logic [XLEN-1:0]  v1, v2;
        logic [TAG_W-1:0] l1, l2;
        if (compareOn) begin
            modelRead(rs1_addr, v1, l1);
            modelRead(rs2_addr, v2, l2);
            check("val1", rf_val1, v1);
            check("label1", {27'd0, rf_label1}, {27'd0, l1});
            check("val2", rf_val2, v2);
            check("label2", {27'd0, rf_label2}, {27'd0, l2});
        end
    end

    task automatic applyStimulus(input logic ren, input logic [4:0] rrd, input logic [4:0] rtag,
                                 input logic cen, input logic [4:0] crd, input logic [31:0] cres,
                                 input logic [4:0] clab, input logic fl, input logic rdy,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        rename_en = ren; rename_rd = rrd; rename_tag = rtag;
        commit_en = cen; commit_rd = crd; commit_res = cres; commit_lab = clab;
        flush_in = fl; rdy_in = rdy; rs1_addr = r1; rs2_addr = r2;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, r1, r2);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] v1, input logic [4:0] l1,
                               input logic [31:0] v2, input logic [4:0] l2);
        #1;
        check({name, ".val1"}, rf_val1, v1);
        check({name, ".label1"}, {27'd0, rf_label1}, {27'd0, l1});
        check({name, ".val2"}, rf_val2, v2);
        check({name, ".label2"}, {27'd0, rf_label2}, {27'd0, l2});
    endtask

    function automatic logic [4:0] pickReg();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        passCount = 0;
        checkCount = 0;
        compareOn = 0;
        clearModel();
        rst_in = 0; rdy_in = 1;
        rename_en = 0; rename_rd = 0; rename_tag = 0;
        commit_en = 0; commit_rd = 0; commit_res = 0; commit_lab = 0;
        flush_in = 0; rs1_addr = 5; rs2_addr = 7;
        #2;
        checkOutput("reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_in = 1;
        compareOn = 1;

        // Writes to x0 are discarded.
        applyStimulus(1, 0, 3, 1, 0, 32'hFFFF_FFFF, 3, 0, 1, 0, 0);
        checkOutput("x0_same", 0, 0, 0, 0);
        idle(0, 5);
        checkOutput("x0_after", 0, 0, 0, 0);

        // Rename then commit with bypass.
        applyStimulus(1, 5, 4, 0, 0, 0, 0, 0, 1, 5, 0);
        idle(5, 0);
        checkOutput("rename_x5", 0, 4, 0, 0);
        applyStimulus(0, 0, 0, 1, 5, 32'h1234, 4, 0, 1, 5, 5);
        checkOutput("bypass_x5", 32'h1234, 0, 32'h1234, 0);
        idle(5, 0);
        checkOutput("commit_x5", 32'h1234, 0, 0, 0);

        // Older commit leaves the younger tag pending.
        applyStimulus(1, 5, 2, 0, 0, 0, 0, 0, 1, 5, 0);
        applyStimulus(1, 5, 6, 0, 0, 0, 0, 0, 1, 5, 0);
        applyStimulus(0, 0, 0, 1, 5, 32'hAA, 2, 0, 1, 5, 0);
        checkOutput("old_commit_same", 32'h1234, 6, 0, 0);
        idle(5, 0);
        checkOutput("old_commit_after", 32'hAA, 6, 0, 0);

        // Same-cycle commit and rename on x9.
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1, 9, 0);
        applyStimulus(1, 9, 7, 1, 9, 32'h55, 1, 0, 1, 9, 0);
        checkOutput("x9_same", 32'h55, 0, 0, 0);
        idle(9, 0);
        checkOutput("x9_after", 32'h55, 7, 0, 0);

        // Flush with simultaneous commit and rename.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 2, 2, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 3, 3, 0, 0, 0, 0, 0, 1, 2, 0);
        checkOutput("pending_x2", 0, 2, 0, 0);
        applyStimulus(1, 4, 5, 1, 1, 32'h77, 9, 1, 1, 0, 0);
        idle(1, 4);
        checkOutput("flush_x1_x4", 32'h77, 0, 0, 0);
        idle(2, 3);
        checkOutput("flush_x2_x3", 0, 0, 0, 0);

        // rdy_in low: no state change and no bypass.
        applyStimulus(1, 6, 3, 1, 5, 32'hDEAD, 0, 0, 0, 5, 6);
        checkOutput("rdy_low_same", 32'hAA, 0, 0, 0);
        idle(5, 6);
        checkOutput("rdy_low_after", 32'hAA, 0, 0, 0);

        // Randomized phase with a reset asserted in the middle.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] crd;
            logic [4:0] clab;
            crd = pickReg();
            clab = ($urandom_range(0, 1) != 0) ? mTag[crd] : 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 1) != 0, pickReg(), 5'($urandom_range(1, ROB_SIZE)),
                          $urandom_range(0, 1) != 0, crd, $urandom, clab,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0,
                          pickReg(), pickReg());
            if (n == 750) begin
                #2;
                rst_in = 0;
                rs1_addr = 5'd5; rs2_addr = 5'd9;
                checkOutput("midrun_reset", 0, 0, 0, 0);
                @(posedge clk); #1;
                rst_in = 1;
            end
        end

        @(posedge clk); #1;
        compareOn = 0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
